// File: rtl/sub_result_pkg.sv
// Shared types and helpers for the sub_result merge block.
package sub_result_pkg;

    localparam int unsigned NUM_SRC_DFLT = 4;
    localparam int unsigned DATA_W_DFLT  = 8;

    // Index width for a source count; never narrower than one bit.
    function automatic int unsigned src_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SRC_W_DFLT = src_idx_w(NUM_SRC_DFLT);

    typedef struct packed {
        logic [SRC_W_DFLT-1:0]  src;
        logic [DATA_W_DFLT-1:0] data;
    } sub_result_t;

endpackage

// File: rtl/sub_result_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr_i, wrapping.
// SUB_RESULT_MERGE_PRIO_EN gives source 0 absolute priority.
module sub_result_rr_arb
    import sub_result_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_SRC_DFLT,
    localparam int unsigned IdxW   = src_idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IdxW-1:0]    rr_ptr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o,
    output logic               valid_o
);

    logic [IdxW:0] pos;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        // Scan offsets high to low so the nearest requester is written last.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr_i} + (IdxW+1)'(k);
            if (pos >= (IdxW+1)'(NUM_SRC)) begin
                pos = pos - (IdxW+1)'(NUM_SRC);
            end
            if (req_i[pos[IdxW-1:0]]) begin
                idx_o   = pos[IdxW-1:0];
                valid_o = 1'b1;
            end
        end
`ifdef SUB_RESULT_MERGE_PRIO_EN
        if (req_i[0]) begin
            idx_o   = '0;
            valid_o = 1'b1;
        end
`endif
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/sub_result_merge.sv
// Merges NUM_SRC result streams through a round-robin arbiter into a tagged FWFT FIFO.
// SUB_RESULT_MERGE_PRIO_EN: source 0 wins whenever valid and does not move rr_ptr.
module sub_result_merge
    import sub_result_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_SRC_DFLT,
    parameter int unsigned DATA_W  = DATA_W_DFLT,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned SrcW   = src_idx_w(NUM_SRC),
    localparam int unsigned AddrW  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        s_valid_i,
    input  logic [NUM_SRC*DATA_W-1:0] s_data_i,
    output logic [NUM_SRC-1:0]        s_ready_o,
    output logic                      m_valid_o,
    output logic [DATA_W-1:0]         m_data_o,
    output logic [SrcW-1:0]           m_src_o,
    input  logic                      m_ready_i,
    output logic [AddrW:0]            fill_level_o
);

    typedef struct packed {
        logic [SrcW-1:0]   src;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t              mem_q [DEPTH];
    logic [AddrW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SrcW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0]  arb_gnt;
    logic [SrcW-1:0]     arb_idx;
    logic                arb_valid;
    logic                full, empty, push, pop;

    sub_result_rr_arb #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .req_i    (s_valid_i),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (arb_gnt),
        .idx_o    (arb_idx),
        .valid_o  (arb_valid)
    );

    // Full is taken from registered pointers only, so m_ready never reaches s_ready.
    assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = arb_valid & ~full;
    assign pop   = ~empty & m_ready_i;

    assign s_ready_o    = full ? '0 : arb_gnt;
    assign m_valid_o    = ~empty;
    assign m_data_o     = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]].data;
    assign m_src_o      = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]].src;
    assign fill_level_o = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AddrW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AddrW+1)'(pop);
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (arb_idx == SrcW'(NUM_SRC - 1)) ? '0 : arb_idx + SrcW'(1);
`ifdef SUB_RESULT_MERGE_PRIO_EN
            if (arb_idx == '0) begin
                rr_ptr_d = rr_ptr_q;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= '{src: arb_idx, data: s_data_i[arb_idx*DATA_W +: DATA_W]};
        end
    end

endmodule

// File: tb/tb_sub_result_merge.sv
// Bench for sub_result_merge: directed table, corner sequences and randomized traffic vs a queue model.
module tb_sub_result_merge;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  s_valid;
    logic [N*DW-1:0] s_data;
    logic [N-1:0]  s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    m_src;
    logic          m_ready;
    logic [2:0]    fill_level;

    sub_result_merge #(
        .NUM_SRC (N),
        .DATA_W  (DW),
        .DEPTH   (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid_i    (s_valid),
        .s_data_i     (s_data),
        .s_ready_o    (s_ready),
        .m_valid_o    (m_valid),
        .m_data_o     (m_data),
        .m_src_o      (m_src),
        .m_ready_i    (m_ready),
        .fill_level_o (fill_level)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: a queue of accepted beats plus the rotation pointer.
    typedef struct {
        int src;
        int data;
    } beat_t;

    beat_t q[$];
    int    rr_m = 0;

    function automatic int model_win(input logic [N-1:0] v);
        if (q.size() == D) return -1;
`ifdef SUB_RESULT_MERGE_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(rr_m + k) % N]) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic cmp_model(input string tag);
        int w;
        w = model_win(s_valid);
        chk({tag, " s_ready"}, 32'(s_ready), (w >= 0) ? 32'(1 << w) : 32'd0);
        chk({tag, " m_valid"}, 32'(m_valid), 32'(q.size() != 0));
        chk({tag, " m_data"}, 32'(m_data), (q.size() != 0) ? 32'(q[0].data) : 32'd0);
        chk({tag, " m_src"}, 32'(m_src), (q.size() != 0) ? 32'(q[0].src) : 32'd0);
        chk({tag, " fill"}, 32'(fill_level), 32'(q.size()));
    endtask

    // Advance one clock; returns the source the model accepted (-1 if none).
    task automatic step(output int w);
        beat_t b;
        w = model_win(s_valid);
        @(posedge clk);
        if (q.size() != 0 && m_ready) void'(q.pop_front());
        if (w >= 0) begin
            b.src  = w;
            b.data = int'(s_data[8*w +: 8]);
            q.push_back(b);
`ifdef SUB_RESULT_MERGE_PRIO_EN
            if (w != 0) rr_m = (w + 1) % N;
`else
            rr_m = (w + 1) % N;
`endif
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = '0;
        m_ready = 1'b0;
        #1;
        chk("reset m_valid", 32'(m_valid), 32'd0);
        chk("reset fill", 32'(fill_level), 32'd0);
        chk("reset s_ready", 32'(s_ready), 32'd0);
        chk("reset m_data", 32'(m_data), 32'd0);
        q.delete();
        rr_m = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  sv;
        logic [31:0] sd;
        logic        mr;
        logic [3:0]  e_rdy;
        logic        e_mv;
        logic [7:0]  e_md;
        logic [1:0]  e_ms;
        logic [2:0]  e_fl;
    } vec_t;

    vec_t tbl[8];
    int   w;
    logic [7:0] pdata [N];
    logic [N-1:0] pend;

    initial begin
        tbl[0] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0};
        tbl[1] = '{4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0, 3'd0};
        tbl[2] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd2, 3'd1};
        tbl[3] = '{4'b0010, 32'h0000_1100, 1'b0, 4'b0010, 1'b0, 8'h00, 2'd0, 3'd0};
        tbl[4] = '{4'b1010, 32'h3300_2100, 1'b1, 4'b1000, 1'b1, 8'h11, 2'd1, 3'd1};
        tbl[5] = '{4'b0010, 32'h0000_2100, 1'b1, 4'b0010, 1'b1, 8'h33, 2'd3, 3'd1};
        tbl[6] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 8'h21, 2'd1, 3'd1};
        tbl[7] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 3'd0};

        s_data = '0;
        do_reset();

        // Idle, single beat latency, and rr wrap-around from rr_ptr=2.
        for (int i = 0; i < 8; i++) begin
            s_valid = tbl[i].sv;
            s_data  = tbl[i].sd;
            m_ready = tbl[i].mr;
            #1;
            chk($sformatf("tbl%0d s_ready", i), 32'(s_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
            chk($sformatf("tbl%0d m_data", i), 32'(m_data), 32'(tbl[i].e_md));
            chk($sformatf("tbl%0d m_src", i), 32'(m_src), 32'(tbl[i].e_ms));
            chk($sformatf("tbl%0d fill", i), 32'(fill_level), 32'(tbl[i].e_fl));
            cmp_model($sformatf("tbl%0d model", i));
            step(w);
        end

`ifndef SUB_RESULT_MERGE_PRIO_EN
        // All sources valid: strict 0,1,2,3 rotation.
        do_reset();
        s_data  = 32'h1312_1110;
        s_valid = 4'b1111;
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr order", 32'(s_ready), 32'(1 << (k % 4)));
            if (k > 0) begin
                chk("rr m_src", 32'(m_src), 32'((k - 1) % 4));
                chk("rr m_data", 32'(m_data), 32'(8'h10 + (k - 1) % 4));
            end
            cmp_model("rr");
            step(w);
        end
`else
        // Source 0 dominates, then rotation resumes from rr_ptr=0.
        do_reset();
        s_data  = 32'h1312_1110;
        s_valid = 4'b1111;
        m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("prio src0", 32'(s_ready), 32'd1);
            cmp_model("prio");
            step(w);
        end
        s_valid = 4'b1110;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("prio rotate", 32'(s_ready), 32'(1 << k));
            cmp_model("prio rot");
            step(w);
        end
`endif

        // Fill to DEPTH, then one pop blocks push for that cycle.
        do_reset();
        s_data  = 32'h4433_2211;
        s_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            cmp_model("fill");
            step(w);
        end
        m_ready = 1'b1;
        #1;
        chk("full fill", 32'(fill_level), 32'd4);
        chk("full s_ready", 32'(s_ready), 32'd0);
        cmp_model("full pop");
        step(w);
        m_ready = 1'b0;
        #1;
        chk("after pop fill", 32'(fill_level), 32'd3);
        chk("after pop s_ready", 32'(s_ready), 32'd1);
        cmp_model("resume");
        step(w);
        #1;
        chk("refill", 32'(fill_level), 32'd4);

        // Mid-stream reset with three queued beats.
        do_reset();
        s_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            #1;
            cmp_model("pre-rst");
            step(w);
        end
        s_valid = '0;
        #1;
        chk("pre-rst fill", 32'(fill_level), 32'd3);
        do_reset();
        s_valid = 4'b1111;
        #1;
        chk("post-rst winner", 32'(s_ready), 32'd1);
        cmp_model("post-rst");
        step(w);

        // Randomized traffic obeying hold-until-ready.
        do_reset();
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    pdata[i] = 8'($urandom);
                end
                s_data[8*i +: 8] = pdata[i];
            end
            s_valid = pend;
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            cmp_model("rand");
            step(w);
            if (w >= 0) pend[w] = 1'b0;
        end
        s_valid = '0;
        m_ready = 1'b1;
        for (int k = 0; k < D + 1; k++) begin
            #1;
            cmp_model("drain");
            step(w);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
